// File: rtl/data_arb_pkg.sv
// Shared types and the round-robin pick helper for the frame-locking data arbiter.
package data_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCK = 1'b1} arb_state_e;

  localparam int unsigned RR_MAX_NUM = 16;
  localparam int unsigned RR_IDX_W   = 4;

  // First set request at or after ptr, scanning upward with wrap. Callers zero-pad
  // requests above their own NUM, so wrapping at RR_MAX_NUM equals wrapping at NUM.
  function automatic logic [RR_MAX_NUM-1:0] rr_pick(input logic [RR_MAX_NUM-1:0] req,
                                                   input logic [RR_IDX_W-1:0]   ptr);
    logic [RR_MAX_NUM-1:0] onehot;
    logic [RR_IDX_W-1:0]   idx;
    logic                  found;
    onehot = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_NUM; k++) begin
      idx = ptr + RR_IDX_W'(k);
      if (!found && req[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin picker: requests plus start pointer give a one-hot pick and its index.
module rr_arbiter_core
  import data_arb_pkg::*;
#(
  parameter int unsigned NUM = 4
) (
  input  logic [NUM-1:0]         req_i,
  input  logic [$clog2(NUM)-1:0] ptr_i,
  output logic [NUM-1:0]         onehot_o,
  output logic [$clog2(NUM)-1:0] index_o
);

  localparam int unsigned IDX_W = $clog2(NUM);

  logic [RR_MAX_NUM-1:0] req_pad;
  logic [RR_MAX_NUM-1:0] pick;

  always_comb begin
    req_pad          = '0;
    req_pad[NUM-1:0] = req_i;
    pick             = rr_pick(req_pad, RR_IDX_W'(ptr_i));
    onehot_o         = pick[NUM-1:0];
    index_o          = '0;
    for (int unsigned k = 0; k < RR_MAX_NUM; k++) begin
      if (pick[k]) index_o = IDX_W'(k);
    end
  end

endmodule

// File: rtl/data_inf_frame_arbiter.sv
// Frame-locking round-robin arbiter sharing one valid/ready/last write channel among NUM requesters,
// with an optional watchdog that drops a grant whose owner stalls mid-frame.
module data_inf_frame_arbiter
  import data_arb_pkg::*;
#(
  parameter int unsigned NUM       = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned STALL_MAX = 0
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [NUM-1:0]         s_valid,
  input  logic [NUM*DSIZE-1:0]   s_data,
  input  logic [NUM-1:0]         s_last,
  output logic [NUM-1:0]         s_ready,
  output logic                   m_valid,
  output logic [DSIZE-1:0]       m_data,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic [NUM-1:0]         grant,
  output logic                   busy,
  output logic                   stall_abort,
  output logic [$clog2(NUM)-1:0] abort_id
);

  localparam int unsigned IDX_W = $clog2(NUM);
  localparam int unsigned CNT_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX);
  localparam bit WD_EN = (STALL_MAX > 0);

  localparam logic [0:0] ST_IDLE = ARB_IDLE;
  localparam logic [0:0] ST_LOCK = ARB_LOCK;

  logic [0:0]       state_q, state_d;
  logic [NUM-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_abort_q, stall_abort_d;
  logic [IDX_W-1:0] abort_id_q, abort_id_d;

  logic [NUM-1:0]   pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] rr_next;
  logic             last_hs;

  rr_arbiter_core #(.NUM(NUM)) u_pick (
    .req_i    (s_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .index_o  (pick_idx)
  );

  // Pass-through mux from the locked owner; everything inactive while idle.
  always_comb begin
    s_ready = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    if (state_q == ST_LOCK) begin
      s_ready = grant_q & {NUM{m_ready}};
      m_valid = |(s_valid & grant_q);
      m_last  = |(s_last & grant_q);
      for (int unsigned k = 0; k < NUM; k++) begin
        if (grant_q[k]) m_data = m_data | s_data[k*DSIZE +: DSIZE];
      end
    end
  end

  assign last_hs = m_valid & m_ready & m_last;
  // Explicit wrap so non-power-of-two NUM never lands on a missing requester.
  assign rr_next = (owner_q == IDX_W'(NUM - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    stall_cnt_d   = stall_cnt_q;
    stall_abort_d = 1'b0;
    abort_id_d    = abort_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|s_valid) begin
          state_d     = ST_LOCK;
          grant_d     = pick_onehot;
          owner_d     = pick_idx;
          stall_cnt_d = '0;
        end
      end
      default: begin
        if (last_hs) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = rr_next;
        end else if (WD_EN && !m_valid) begin
          if (stall_cnt_q == STALL_LIM) begin
            state_d       = ST_IDLE;
            grant_d       = '0;
            rr_ptr_d      = rr_next;
            stall_abort_d = 1'b1;
            abort_id_d    = owner_q;
            stall_cnt_d   = '0;
          end else begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end else begin
          stall_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      stall_cnt_q   <= '0;
      stall_abort_q <= 1'b0;
      abort_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      stall_cnt_q   <= stall_cnt_d;
      stall_abort_q <= stall_abort_d;
      abort_id_q    <= abort_id_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == ST_LOCK);
  assign stall_abort = stall_abort_q;
  assign abort_id    = abort_id_q;

endmodule
